// File: rtl/req_encoder8_3_if.sv
// Request/encoded-index bus between event sources and the round-robin encoder.
// The master drives requests and consumes indices; the encoder is the slave.
interface req_encoder8_3_if;
   logic       enable;
   logic [7:0] req;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] pending;

   modport master (
      output enable, req, out_ready,
      input  out_valid, out_idx, pending
   );

   modport slave (
      input  enable, req, out_ready,
      output out_valid, out_idx, pending
   );
endinterface

// File: rtl/req_encoder8_3.sv
// Round-robin 8-to-3 request encoder: sticky pending bits, fair search from ptr,
// and a registered valid/ready output stage emitting one index per cycle.
module req_encoder8_3_lane (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clr,
   output logic pend
);
   // Set wins over clear so a re-request on the serving edge is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend <= 1'b0;
      else       pend <= (pend & ~clr) | set;
   end
endmodule

module req_encoder8_3 (
   input  logic             clk,
   input  logic             reset,
   req_encoder8_3_if.slave  bus
);
   localparam int NUM_LANES = 8;

   typedef enum logic {S_IDLE, S_VALID} state_t;

   state_t                 state, state_nxt;
   logic [2:0]             ptr, ptr_nxt;
   logic [2:0]             idx_q, idx_nxt;
   logic [2:0]             winner, cand;
   logic                   found;
   logic                   stage_free;
   logic                   load;
   logic [NUM_LANES-1:0]   pend, set, clr;

   assign set = bus.enable ? bus.req : '0;

   req_encoder8_3_lane u_lane [NUM_LANES-1:0] (
      .clk   (clk),
      .reset (reset),
      .set   (set),
      .clr   (clr),
      .pend  (pend)
   );

   // First pending bit at or after ptr, wrapping modulo 8.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      cand   = ptr;
      for (int i = 0; i < NUM_LANES; i++) begin
         cand = ptr + 3'(i);
         if (!found && pend[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign stage_free = (state == S_IDLE) || bus.out_ready;
   assign load       = stage_free && found;
   assign clr        = load ? (NUM_LANES'(1) << winner) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         ptr   <= '0;
         idx_q <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         idx_q <= idx_nxt;
      end
   end

   // Index and pointer only move on a load; a stalled stage holds both.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = idx_q;
      if (stage_free) begin
         if (found) begin
            state_nxt = S_VALID;
            idx_nxt   = winner;
            ptr_nxt   = winner + 3'd1;
         end else begin
            state_nxt = S_IDLE;
         end
      end
   end

   assign bus.out_valid = (state == S_VALID);
   assign bus.out_idx   = idx_q;
   assign bus.pending   = pend;
endmodule

// File: tb/tb_req_encoder8_3.sv
// Directed bench for req_encoder8_3: reset, single, burst, backpressure,
// round-robin wrap, enable gating, set-wins and mid-burst reset.
module tb_req_encoder8_3;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   req_encoder8_3_if bus ();

   req_encoder8_3 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] idx, input logic [7:0] p);
      chk({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd1);
      chk({tag, ".idx"},   {5'd0, bus.out_idx},   {5'd0, idx});
      chk({tag, ".pend"},  bus.pending,           p);
   endtask

   task automatic expect_idle(input string tag, input logic [7:0] p);
      chk({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd0);
      chk({tag, ".pend"},  bus.pending,           p);
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      #1;
      expect_idle("rst_pulse", 8'h00);
      chk("rst_pulse.idx", {5'd0, bus.out_idx}, 8'd0);
      tick;
      reset = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.req       = 8'h00;
      bus.out_ready = 1'b0;

      // Reset state
      tick; tick;
      expect_idle("reset", 8'h00);
      chk("reset.idx", {5'd0, bus.out_idx}, 8'd0);
      reset = 1'b0;
      tick; tick;
      expect_idle("post_reset", 8'h00);
      chk("post_reset.idx", {5'd0, bus.out_idx}, 8'd0);

      // Single request: valid two edges after req is applied, for one cycle
      bus.enable = 1'b1; bus.out_ready = 1'b1; bus.req = 8'h01;
      tick;
      expect_idle("single.capture", 8'h01);
      bus.req = 8'h00;
      tick;
      expect_out("single.out", 3'd0, 8'h00);
      tick;
      expect_idle("single.done", 8'h00);

      // Burst of eight from a fresh pointer
      pulse_reset;
      bus.req = 8'hFF;
      tick;
      expect_idle("burst.capture", 8'hFF);
      bus.req = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick;
         expect_out($sformatf("burst%0d", i), 3'(i), 8'(8'hFF << (i + 1)));
      end
      tick;
      expect_idle("burst.done", 8'h00);

      // Backpressure: index 2 held five cycles, then 5 (ptr is 0 here)
      bus.out_ready = 1'b0; bus.req = 8'h24;
      tick;
      expect_idle("bp.capture", 8'h24);
      bus.req = 8'h00;
      tick;
      expect_out("bp.hold0", 3'd2, 8'h20);
      for (int i = 1; i < 5; i++) begin
         tick;
         expect_out($sformatf("bp.hold%0d", i), 3'd2, 8'h20);
      end
      bus.out_ready = 1'b1;
      tick;
      expect_out("bp.next", 3'd5, 8'h00);
      tick;
      expect_idle("bp.done", 8'h00);

      // Round-robin wrap
      bus.req = 8'h40;
      tick; bus.req = 8'h00;
      tick;
      expect_out("rr.six", 3'd6, 8'h00);
      tick;
      bus.req = 8'h41;
      tick; bus.req = 8'h00;
      tick;
      expect_out("rr41.a", 3'd0, 8'h40);
      tick;
      expect_out("rr41.b", 3'd6, 8'h00);
      tick;
      expect_idle("rr41.done", 8'h00);
      bus.req = 8'h81;
      tick; bus.req = 8'h00;
      tick;
      expect_out("rr81.a", 3'd7, 8'h01);
      tick;
      expect_out("rr81.b", 3'd0, 8'h00);
      tick;
      expect_idle("rr81.done", 8'h00);

      // Enable gating
      bus.enable = 1'b0; bus.req = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick;
         expect_idle($sformatf("en_off%0d", i), 8'h00);
      end
      bus.req = 8'h00; bus.enable = 1'b1;

      // Set wins: re-request bit 3 on the edge it loads
      bus.req = 8'h08;
      tick;
      expect_idle("sw.capture", 8'h08);
      tick;
      expect_out("sw.first", 3'd3, 8'h08);
      bus.req = 8'h00;
      tick;
      expect_out("sw.second", 3'd3, 8'h00);
      tick;
      expect_idle("sw.done", 8'h00);

      // Mid-cycle asynchronous reset with A5 pending and valid output
      bus.out_ready = 1'b0; bus.req = 8'hA5;
      tick;
      expect_idle("mr.capture", 8'hA5);
      tick;
      expect_out("mr.loaded", 3'd5, 8'hA5);
      bus.req = 8'h00;
      #3 reset = 1'b1;
      #1;
      expect_idle("mr.async", 8'h00);
      chk("mr.async.idx", {5'd0, bus.out_idx}, 8'd0);
      tick;
      reset = 1'b0;
      tick; tick;
      expect_idle("mr.after", 8'h00);
      chk("mr.after.idx", {5'd0, bus.out_idx}, 8'd0);

      // Pointer back at 0 after reset
      bus.out_ready = 1'b1; bus.req = 8'h81;
      tick; bus.req = 8'h00;
      tick;
      expect_out("ptr0.a", 3'd0, 8'h80);
      tick;
      expect_out("ptr0.b", 3'd7, 8'h00);
      tick;
      expect_idle("ptr0.done", 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/req_encoder8_3.md
# req_encoder8_3

Round-robin request encoder that turns up to eight independent request lines into a stream of 3-bit indices. It is the inverse of the 3-to-8 write-select decoder: the decoder expands an index into a one-hot select, and this block collapses a multi-hot request vector into one index per cycle. Requests are latched into sticky pending bits and served fairly through a valid/ready output. It sits between event sources (interrupt lines, register-port requesters) and any consumer that wants a single encoded index.

## Interface
Parameters: none; width is fixed at 8 requests and a 3-bit index.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when 1, `req` is captured; when 0, `req` is ignored. Output draining continues while `enable` is 0.
- req  in  8  request vector; a bit high at an edge sets the matching pending bit.
- out_ready  in  1  consumer accepts `out_idx` at an edge where `out_valid` and `out_ready` are both 1.
- out_valid  out  1  `out_idx` holds a valid encoded request.
- out_idx  out  3  encoded index of the served request.
- pending  out  8  current sticky pending bits, registered.

## Operation
Pending register:
- At each edge: `pending <= (pending & ~clr) | (enable ? req : 0)`.
- `clr` is the one-hot of the index loaded into the output stage at that edge.
- Set wins: if a bit is cleared and re-requested at the same edge, it stays pending.
- A request for a bit that is already pending merges into it. There is no count and no overflow.

Selection:
- Pure combinational round-robin search over the registered `pending`.
- Search starts at `ptr` and proceeds `ptr, ptr+1, …, ptr+7`, modulo 8.
- `ptr` is 3 bits and wraps naturally. At each load, `ptr <= loaded_idx + 1`, so loading index 7 gives `ptr = 0`.

Output stage:
- A load happens when `pending != 0` and the stage is free.
- The stage is free when `out_valid == 0`, or when `out_valid & out_ready` at this edge.
- On load: `out_valid <= 1`, `out_idx <= winner`, the winner's bit is cleared, and `ptr` is updated.
- If the stage is free and nothing is pending: `out_valid <= 0`. `out_idx` holds its last value.
- While `out_valid == 1` and `out_ready == 0`:
  - `out_idx` and `ptr` are held.
  - `pending` still accepts new requests.

Reset (asynchronous, effective immediately, including mid-burst):
- `pending = 0`, `out_valid = 0`, `out_idx = 0`, `ptr = 0`.
- Index 0 has first priority after reset.
- Any in-flight index is dropped.

## Timing
- Latency: `req` sampled at edge k → bit set in `pending` after edge k → `out_valid = 1` with the index after edge k+1, with the output stage free.
- Throughput: one index per cycle while `out_ready = 1` and `pending != 0`.
- Draining: eight simultaneous requests are fully served in 8 consecutive cycles.
- `out_valid` and `out_idx` are registered, with no combinational path from `req` or `out_ready` to them.
- `pending` is registered.
- Handshake:
  - Once asserted, `out_valid` stays high and `out_idx` stays stable until accepted.
  - `out_ready` may be high while `out_valid` is low; this has no effect.
- `enable` acts only on capture. Toggling it never clears existing pending bits.

## Test plan
- **Reset:** assert `reset` mid-cycle with `pending = 8'hA5` and `out_valid = 1` → immediately `pending = 0`, `out_valid = 0`, `out_idx = 0`. After release with `req = 0`, all outputs stay 0.
- **Single request:** `enable = 1`, `out_ready = 1`, `req = 8'h01` for one cycle → `out_valid = 1`, `out_idx = 0` for exactly one cycle, starting 2 edges after `req` is applied. Then `out_valid = 0` and `pending = 0`.
- **Burst:** `req = 8'hFF` for one cycle, `out_ready = 1` → `out_idx` = 0,1,2,3,4,5,6,7 on 8 consecutive cycles, then `out_valid = 0`. `pending` steps from 8'hFE down to 8'h00.
- **Backpressure:** `out_ready = 0`, `req = 8'h24` once → `out_valid = 1` with `out_idx = 2`, held for 5 cycles, and `pending = 8'h20`. Raise `out_ready` → the next cycle gives `out_idx = 5`, then `out_valid = 0`.
- **Round-robin wrap:**
  - Serve index 6 alone (`ptr` becomes 7).
  - Then `req = 8'h41` → `out_idx = 0` then 6.
  - Then `req = 8'h81` → `out_idx = 7` then 0.
- **Enable and set-wins:**
  - `enable = 0` with `req = 8'hFF` for 4 cycles → `pending` stays 0 and `out_valid` stays 0.
  - With `enable = 1`, re-assert `req[3]` on the edge where index 3 loads → `pending[3]` remains 1 and index 3 is emitted a second time.
